// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl.sv
// Frame sequencer for the xnor3 parity datapath: accepts NWORDS triplets, folds each
// xnor3 result into a running XOR and presents the frame parity over a handshake.
module gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl #(
  parameter int unsigned NWORDS = 8
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  input  logic START,
  input  logic ABORT,
  input  logic IN_VALID,
  output logic IN_READY,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic OUT_VALID,
  input  logic OUT_READY,
  output logic ZN,
  output logic BUSY
);

  localparam int unsigned CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_t;

  state_t        state_q;
  logic          acc_q;
  logic [CW-1:0] cnt_q;
  logic          zn_q;
  logic          word;

  assign word = ~(A1 ^ A2 ^ A3);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      zn_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StAcc;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StAcc: begin
          // ABORT wins over a triplet presented in the same cycle.
          if (ABORT) begin
            state_q <= StIdle;
          end else if (IN_VALID) begin
            acc_q <= acc_q ^ word;
            if (cnt_q == LAST) begin
              state_q <= StDone;
              zn_q    <= acc_q ^ word;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        StDone: begin
          if (OUT_READY) begin
            if (START) begin
              state_q <= StAcc;
              acc_q   <= 1'b0;
              cnt_q   <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign IN_READY  = (state_q == StAcc);
  assign OUT_VALID = (state_q == StDone);
  assign BUSY      = (state_q != StIdle);
  assign ZN        = zn_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl.sv
// Directed bench for the xnor3 frame controller: NWORDS=4 instance for the main
// scenarios, NWORDS=1 instance for the single-triplet frame.
module tb_gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  logic start, abort, in_valid, a1, a2, a3, out_ready;
  logic in_ready, out_valid, zn, busy;
  logic start1, in_valid1, b1, b2, b3, out_ready1;
  logic in_ready1, out_valid1, zn1, busy1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl #(.NWORDS(4)) dut4 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss),
    .START(start), .ABORT(abort), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A1(a1), .A2(a2), .A3(a3),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .ZN(zn), .BUSY(busy)
  );

  gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl #(.NWORDS(1)) dut1 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss),
    .START(start1), .ABORT(1'b0), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .A1(b1), .A2(b2), .A3(b3),
    .OUT_VALID(out_valid1), .OUT_READY(out_ready1), .ZN(zn1), .BUSY(busy1)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic x1, input logic x2, input logic x3);
    in_valid = 1'b1;
    a1 = x1; a2 = x2; a3 = x3;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    start = 0; abort = 0; in_valid = 0; a1 = 0; a2 = 0; a3 = 0; out_ready = 0;
    start1 = 0; in_valid1 = 0; b1 = 0; b2 = 0; b3 = 0; out_ready1 = 0;

    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_zn", zn, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    rn = 1'b1;
    tick();

    // Nominal: w = 1,0,0,1 -> ZN = 0
    begin_frame();
    check("nom_in_ready", in_ready, 1'b1);
    check("nom_busy", busy, 1'b1);
    send(0, 0, 0);
    send(1, 1, 1);
    send(1, 0, 0);
    check("nom_not_done_early", out_valid, 1'b0);
    send(1, 1, 0);
    check("nom_out_valid", out_valid, 1'b1);
    check("nom_zn", zn, 1'b0);
    check("nom_in_ready_done", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("nom_busy_after", busy, 1'b0);

    // Gaps and backpressure: w = 1,1,1,0 -> ZN = 1
    begin_frame();
    send(0, 0, 0); tick(); tick();
    send(0, 0, 0); tick(); tick();
    send(0, 0, 0); tick(); tick();
    check("gap_not_done_early", out_valid, 1'b0);
    send(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_zn", zn, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", busy, 1'b0);

    // Abort after two accepts leaving acc=1; the blocked triplet (w=1) is dropped
    begin_frame();
    send(0, 0, 0);
    send(1, 1, 1);
    abort = 1'b1;
    send(0, 0, 0);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    begin_frame();
    send(1, 1, 1);
    send(1, 1, 1);
    send(1, 1, 1);
    check("abort_cnt_restart", out_valid, 1'b0);
    send(1, 1, 1);
    check("abort_new_valid", out_valid, 1'b1);
    check("abort_new_zn", zn, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back: first frame ZN=1, second frame also 1 only if acc cleared
    begin_frame();
    send(0, 0, 0); send(1, 1, 1); send(1, 1, 1); send(1, 1, 1);
    check("b2b_first_zn", zn, 1'b1);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("b2b_in_ready", in_ready, 1'b1);
    check("b2b_out_valid", out_valid, 1'b0);
    send(0, 0, 0); send(1, 1, 1); send(1, 1, 1); send(1, 1, 1);
    check("b2b_second_valid", out_valid, 1'b1);
    check("b2b_second_zn", zn, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-frame, between edges (ZN currently 1)
    begin_frame();
    send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
    #2;
    rn = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_zn", zn, 1'b0);
    check("rst_mid_out_valid", out_valid, 1'b0);
    #2;
    rn = 1'b1;
    tick();
    // w = 1,0,0,0 -> ZN = 1
    begin_frame();
    send(0, 0, 0); send(1, 1, 1); send(1, 1, 1);
    check("rst_new_not_early", out_valid, 1'b0);
    send(1, 1, 1);
    check("rst_new_valid", out_valid, 1'b1);
    check("rst_new_zn", zn, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // NWORDS=1: single triplet (0,1,1) -> w = 1
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("n1_in_ready", in_ready1, 1'b1);
    check("n1_out_valid_pre", out_valid1, 1'b0);
    in_valid1 = 1'b1; b1 = 0; b2 = 1; b3 = 1;
    tick();
    in_valid1 = 1'b0;
    check("n1_out_valid", out_valid1, 1'b1);
    check("n1_zn", zn1, 1'b1);
    check("n1_in_ready_done", in_ready1, 1'b0);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("n1_idle", busy1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl.md
# gf180mcu_fd_sc_mcu9t5v0__xnor3_frame_ctl

Sequencing controller for the 3-input XNOR (xnor3) parity datapath. It accepts a frame of NWORDS 3-bit triplets over a valid/ready handshake and evaluates each triplet through one shared xnor3 function. The per-triplet results are XOR-accumulated into a single frame-parity bit. That bit is presented on an output handshake. The block sits between a triplet source (scan/BIST or checker logic) and the consumer of the frame-parity bit.

## Interface
- NWORDS, 8: triplets per frame; legal range 1..256; counter width CW = max(1, clog2(NWORDS)).
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- VDD, VSS  inout  1  supply pins; no logic function.
- START  input  1  begin a frame; sampled only in IDLE, or in DONE together with OUT_READY.
- ABORT  input  1  cancel the current frame; honoured only in ACC.
- IN_VALID  input  1  triplet A1/A2/A3 valid.
- IN_READY  output  1  block accepts a triplet this cycle.
- A1, A2, A3  input  1 each  triplet bits.
- OUT_VALID  output  1  ZN holds a completed frame result.
- OUT_READY  input  1  consumer takes ZN.
- ZN  output  1  frame parity result.
- BUSY  output  1  state != IDLE.

## Operation
- Triplet function: w = ~(A1 ^ A2 ^ A3).
- Accumulator update on accept: acc <= acc ^ w. Accept occurs when IN_VALID & IN_READY at a CLK edge.
- State IDLE: IN_READY=0, OUT_VALID=0.
  - START=1 -> ACC, with acc<=0 and cnt<=0.
- State ACC: IN_READY=1. Priority order:
  1. ABORT=1 -> IDLE. Any triplet presented that cycle is not accepted and acc is unchanged; no result is produced.
  2. Accept with cnt==NWORDS-1 -> DONE, with ZN <= acc ^ w and cnt<=0.
  3. Accept otherwise -> cnt<=cnt+1.
  4. IN_VALID=0 -> hold state, cnt and acc.
- State DONE: OUT_VALID=1, ZN held stable, IN_READY=0.
  - OUT_READY=1 and START=0 -> IDLE.
  - OUT_READY=1 and START=1 -> ACC directly, with acc<=0 and cnt<=0 (back-to-back frames).
  - OUT_READY=0 -> hold; START and ABORT are ignored.
- START in ACC is ignored. ABORT in IDLE or DONE is ignored.
- IN_READY is a pure state decode and does not depend on IN_VALID.
- NWORDS=1: the first accept goes straight to DONE.
- cnt never exceeds NWORDS-1, so no wrap-around occurs.

## Timing
- Reset (RN=0, asynchronous assert): state=IDLE, acc=0, cnt=0, ZN=0, OUT_VALID=0, IN_READY=0, BUSY=0. Release is synchronous to the next CLK edge; the first START is sampled on the first edge after release.
- Reset during any state aborts the frame immediately; no partial result is emitted.
- START sampled at edge k -> IN_READY=1 and BUSY=1 from edge k onward.
- Last triplet accepted at edge n -> OUT_VALID=1 and ZN valid from edge n. Latency is one edge after the final accept.
- Minimum frame period without stalls is NWORDS+1 cycles, using back-to-back START.
- All outputs are registered or pure decodes of state registers; there are no combinational paths from inputs to outputs.

## Test plan
- Nominal, NWORDS=4: START, then triplets (0,0,0), (1,1,1), (1,0,0), (1,1,0) with IN_VALID held high.
  - w sequence is 1, 0, 0, 1.
  - Required: OUT_VALID rises on the edge after the 4th accept, with ZN=0.
  - OUT_READY=1 -> BUSY=0 on the next edge.
- Gaps and backpressure: triplets (0,0,0), (0,0,0), (0,0,0), (0,0,1) with IN_VALID low 2 cycles between each, and OUT_READY held low 5 cycles.
  - Required: ZN=1, stable for all 5 cycles with OUT_VALID=1; IN_READY=0 throughout DONE.
- ABORT after 2 accepts, then a new frame of four (1,1,1) triplets.
  - Required: no OUT_VALID for the aborted frame; the new frame gives ZN=0; cnt restarts from 0.
- Back-to-back: in DONE drive OUT_READY=1 and START=1 in the same cycle.
  - Required: next cycle IN_READY=1, OUT_VALID=0, acc cleared; the next result is independent of the previous ZN.
- Reset mid-frame: assert RN after 3 accepts, between edges.
  - Required: IN_READY, BUSY and ZN go to 0 immediately; after release, a new 4-triplet frame produces the correct ZN.
- NWORDS=1: START, then (0,1,1).
  - Required: DONE on the edge after the single accept, with ZN=1.
